// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: frame mode encodings, the bridge slave FSM state type and a
// helper that sizes the bit counters.
package bus_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        REQ,
        WAIT_RSP,
        RDATA
    } bridge_slave_state_t;

    // Counter wide enough to index the longer of the two fields, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bridge_serdes.sv
// Right-shifting register with a bit counter. Serial-in bits enter at the MSB so an LSB-first
// stream lands in place after WIDTH shifts; serial-out is par_out[0] while shifting.
module bridge_serdes #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = par_in;
            cnt_d  = '0;
        end else if (shift) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
        end
        // Clear wins so the final shift of a field leaves the counter at zero for the next one.
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign par_out = data_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/bus_bridge_slave.sv
// Serial-bus slave endpoint for the bus bridge: collects a frame into one parallel request to the
// remote side and streams the read response back, optionally releasing the bus while it waits.
module bus_bridge_slave
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          SPLIT_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mode,
    input  logic                  wr_bus,
    input  logic                  master_valid,
    input  logic                  master_ready,
    output logic                  rd_bus,
    output logic                  slave_ready,
    output logic                  slave_valid,
    output logic                  split,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_write,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  rsp_valid,
    input  logic [DATA_WIDTH-1:0] rsp_rdata
);

    localparam int unsigned      CNT_W     = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    bridge_slave_state_t state_q, state_d;
    logic                mode_q, mode_d;

    logic                  addr_shift, addr_clr;
    logic                  data_shift, data_clr, data_load, data_ser_in;
    logic [CNT_W-1:0]      addr_cnt, data_cnt;
    logic [ADDR_WIDTH-1:0] addr_par;
    logic [DATA_WIDTH-1:0] data_par;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        addr_shift  = 1'b0;
        addr_clr    = 1'b0;
        data_shift  = 1'b0;
        data_clr    = 1'b0;
        data_load   = 1'b0;
        data_ser_in = 1'b0;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        split       = 1'b0;
        req_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    mode_d     = mode;
                    addr_shift = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    addr_shift = 1'b1;
                    if (addr_cnt == ADDR_LAST) begin
                        addr_clr = 1'b1;
                        state_d  = (mode_q == MODE_WRITE) ? WDATA : REQ;
                    end
                end
            end
            WDATA: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    data_shift  = 1'b1;
                    data_ser_in = wr_bus;
                    if (data_cnt == DATA_LAST) begin
                        data_clr = 1'b1;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_d = (mode_q == MODE_WRITE) ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                split = SPLIT_EN;
                if (rsp_valid) begin
                    data_load = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                slave_valid = 1'b1;
                if (master_ready) begin
                    data_shift = 1'b1;
                    if (data_cnt == DATA_LAST) begin
                        data_clr = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= MODE_READ;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // The IDLE-cycle shift captures address bit 0, so the counter enters ADDR at one.
    bridge_serdes #(
        .WIDTH (ADDR_WIDTH),
        .CNT_W (CNT_W)
    ) u_addr_serdes (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (addr_clr),
        .load    (1'b0),
        .shift   (addr_shift),
        .ser_in  (wr_bus),
        .par_in  ('0),
        .par_out (addr_par),
        .cnt     (addr_cnt)
    );

    // Shared between inbound write data and the outbound read response.
    bridge_serdes #(
        .WIDTH (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_data_serdes (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (data_clr),
        .load    (data_load),
        .shift   (data_shift),
        .ser_in  (data_ser_in),
        .par_in  (rsp_rdata),
        .par_out (data_par),
        .cnt     (data_cnt)
    );

    assign rd_bus    = slave_valid & data_par[0];
    assign req_write = mode_q;
    assign req_addr  = addr_par;
    assign req_wdata = data_par;

endmodule

// File: tb/tb_bus_bridge_slave.sv
// Directed bench for bus_bridge_slave; a split-enabled and a split-disabled instance share stimulus.
module tb_bus_bridge_slave;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          mode, wr_bus, master_valid, master_ready, req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;

    logic          d1_rd_bus, d1_slave_ready, d1_slave_valid, d1_split, d1_req_valid, d1_req_write;
    logic [AW-1:0] d1_req_addr;
    logic [DW-1:0] d1_req_wdata;
    logic          d0_rd_bus, d0_slave_ready, d0_slave_valid, d0_split, d0_req_valid, d0_req_write;
    logic [AW-1:0] d0_req_addr;
    logic [DW-1:0] d0_req_wdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_bridge_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(1'b1)) u_dut_split (
        .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
        .master_ready(master_ready), .rd_bus(d1_rd_bus), .slave_ready(d1_slave_ready),
        .slave_valid(d1_slave_valid), .split(d1_split), .req_valid(d1_req_valid),
        .req_ready(req_ready), .req_write(d1_req_write), .req_addr(d1_req_addr),
        .req_wdata(d1_req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    bus_bridge_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPLIT_EN(1'b0)) u_dut_hold (
        .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .master_valid(master_valid),
        .master_ready(master_ready), .rd_bus(d0_rd_bus), .slave_ready(d0_slave_ready),
        .slave_valid(d0_slave_valid), .split(d0_split), .req_valid(d0_req_valid),
        .req_ready(req_ready), .req_write(d0_req_write), .req_addr(d0_req_addr),
        .req_wdata(d0_req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic drive_bit(input logic b);
        master_valid = 1'b1;
        wr_bus       = b;
        @(negedge clk);
        master_valid = 1'b0;
        wr_bus       = 1'b0;
    endtask

    task automatic send_frame(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int stall_at);
        mode = m;
        for (int i = 0; i < int'(AW); i++) begin
            if (i == stall_at) begin
                repeat (3) @(negedge clk);
                check("addr_stall_rdy", d1_slave_ready, 1);
            end
            drive_bit(a[i]);
        end
        if (m) begin
            for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
        end
    endtask

    task automatic check_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check("req_valid", d1_req_valid, 1);
        check("req_write", d1_req_write, w);
        check("req_addr", d1_req_addr, a);
        check("req_addr_hold", d0_req_addr, a);
        if (w) check("req_wdata", d1_req_wdata, d);
        check("req_busy_rdy", d1_slave_ready, 0);
    endtask

    task automatic handshake(input logic junk_rsp, input logic [DW-1:0] junk);
        req_ready = 1'b1;
        if (junk_rsp) begin
            rsp_valid = 1'b1;
            rsp_rdata = junk;
        end
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b0;
    endtask

    task automatic recv_data(input logic [DW-1:0] exp, input int stall_at);
        logic [DW-1:0] got;
        got = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (i == stall_at) begin
                master_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check("rd_stall_bit", d1_rd_bus, exp[i]);
                end
            end
            check("rd_valid", d1_slave_valid, 1);
            check("rd_bit", d1_rd_bus, exp[i]);
            check("rd_bit_hold", d0_rd_bus, exp[i]);
            got[i] = d1_rd_bus;
            master_ready = 1'b1;
            @(negedge clk);
            master_ready = 1'b0;
        end
        check("rd_word", got, exp);
        check("rd_done_valid", d1_slave_valid, 0);
        check("rd_done_rdy", d1_slave_ready, 1);
    endtask

    task automatic read_txn(input logic [AW-1:0] a, input logic [DW-1:0] rsp, input int wait_cyc,
                            input int addr_stall, input int rd_stall, input logic junk_rsp);
        int split1_bad, split0_bad, valid_bad;
        send_frame(1'b0, a, '0, addr_stall);
        check_req(1'b0, a, '0);
        handshake(junk_rsp, ~rsp);
        split1_bad = 0;
        split0_bad = 0;
        valid_bad  = 0;
        for (int i = 0; i < wait_cyc; i++) begin
            if (d1_split !== 1'b1) split1_bad++;
            if (d0_split !== 1'b0) split0_bad++;
            if (d1_slave_valid !== 1'b0 || d1_slave_ready !== 1'b0) valid_bad++;
            @(negedge clk);
        end
        check("split_wait", split1_bad, 0);
        check("nosplit_wait", split0_bad, 0);
        check("wait_idle_bus", valid_bad, 0);
        check("split_rsp_cycle", d1_split, 1);
        rsp_valid = 1'b1;
        rsp_rdata = rsp;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        check("split_fall", d1_split, 0);
        check("nosplit_rdata", d0_split, 0);
        recv_data(rsp, rd_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rstn = 1'b0; mode = 1'b0; wr_bus = 1'b0; master_valid = 1'b0; master_ready = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_slave_ready", d1_slave_ready, 1);
        check("rst_rd_bus", d1_rd_bus, 0);
        check("rst_slave_valid", d1_slave_valid, 0);
        check("rst_split", d1_split, 0);
        check("rst_req_valid", d1_req_valid, 0);
        check("rst_req_write", d1_req_write, 0);
        check("rst_req_addr", d1_req_addr, 0);
        check("rst_req_wdata", d1_req_wdata, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Plain write
        send_frame(1'b1, 12'h0A5, 8'h3C, -1);
        check_req(1'b1, 12'h0A5, 8'h3C);
        handshake(1'b0, '0);
        check("wr_rdy_back", d1_slave_ready, 1);
        check("wr_req_drop", d1_req_valid, 0);

        // Reads: long wait, junk response in handshake cycle, stalls on both directions
        read_txn(12'h123, 8'hE7, 19, -1, -1, 1'b0);
        read_txn(12'h3C8, 8'hE7, 5, -1, -1, 1'b1);
        read_txn(12'h9B4, 8'h5A, 7, 5, 3, 1'b0);

        // Far side back-pressure with stray master_valid pulses
        send_frame(1'b1, 12'h456, 8'h9D, -1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (d1_req_valid !== 1'b1 || d1_req_write !== 1'b1 || d1_req_addr !== 12'h456 ||
                d1_req_wdata !== 8'h9D || d1_slave_ready !== 1'b0) bad++;
            master_valid = 1'b1;
            wr_bus       = 1'($urandom_range(0, 1));
            mode         = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        master_valid = 1'b0;
        check("bp_stable", bad, 0);
        check_req(1'b1, 12'h456, 8'h9D);
        handshake(1'b0, '0);
        check("bp_rdy_back", d1_slave_ready, 1);
        send_frame(1'b1, 12'h001, 8'hFF, -1);
        check_req(1'b1, 12'h001, 8'hFF);
        handshake(1'b0, '0);

        // Reset in the middle of write data aborts the frame
        mode = 1'b1;
        for (int i = 0; i < int'(AW); i++) drive_bit(1'b1);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rstn = 1'b0;
        #1;
        check("abort_req_valid", d1_req_valid, 0);
        check("abort_slave_ready", d1_slave_ready, 1);
        check("abort_req_addr", d1_req_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (d1_req_valid !== 1'b0 || d1_slave_ready !== 1'b1) bad++;
        end
        check("abort_no_req", bad, 0);
        send_frame(1'b1, 12'h7FF, 8'h81, -1);
        check_req(1'b1, 12'h7FF, 8'h81);
        handshake(1'b0, '0);
        check("final_rdy", d1_slave_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
